// File: rtl/io_ring_seq_pkg.sv
// Shared types and sizing helpers for the IO ring power sequencer.
package io_ring_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_WAIT_SUP = 3'd1,
        ST_RAMP_UP  = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_ON       = 3'd4,
        ST_RAMP_DN  = 3'd5,
        ST_FAULT    = 3'd6
    } state_t;

    localparam int DEF_N_GROUPS       = 4;
    localparam int DEF_STAGGER_CYC    = 16;
    localparam int DEF_ISO_SETTLE_CYC = 8;
    localparam int DEF_SUPPLY_TO_CYC  = 1024;

    // One spare bit above the largest interval so the counter never wraps.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_ring_pwr_seq_if.sv
// Control/status bundle between the always-on controller and the IO ring sequencer.
interface io_ring_pwr_seq_if
    import io_ring_seq_pkg::*;
#(
    parameter int N_GROUPS = DEF_N_GROUPS
);

    // No valid/ready handshake: pwr_up_req is a level (1 = keep ring up),
    // supply flags are asynchronous levels, fault_clr is a one-cycle pulse;
    // every status output is a registered level.
    logic                pwr_up_req;
    logic                vddio_good_a;
    logic                vdd_good_a;
    logic                fault_clr;
    logic [N_GROUPS-1:0] grp_en_o;
    logic                iso_en_o;
    logic                ring_ready_o;
    logic                fault_o;
    logic [2:0]          state_o;

    modport master (
        output pwr_up_req, vddio_good_a, vdd_good_a, fault_clr,
        input  grp_en_o, iso_en_o, ring_ready_o, fault_o, state_o
    );

    modport slave (
        input  pwr_up_req, vddio_good_a, vdd_good_a, fault_clr,
        output grp_en_o, iso_en_o, ring_ready_o, fault_o, state_o
    );

endinterface

// File: rtl/io_sync2.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
module io_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/io_ring_pwr_seq.sv
// IO pad ring sequencer: staggered group enables after supplies are good,
// isolation released last, staggered or immediate (fault) shutdown.
module io_ring_pwr_seq
    import io_ring_seq_pkg::*;
#(
    parameter int N_GROUPS       = DEF_N_GROUPS,
    parameter int STAGGER_CYC    = DEF_STAGGER_CYC,
    parameter int ISO_SETTLE_CYC = DEF_ISO_SETTLE_CYC,
    parameter int SUPPLY_TO_CYC  = DEF_SUPPLY_TO_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    io_ring_pwr_seq_if.slave bus
);

    localparam int CW = cnt_width(STAGGER_CYC, ISO_SETTLE_CYC, SUPPLY_TO_CYC);
    localparam int GW = idx_width(N_GROUPS);

    localparam logic [CW-1:0] STG_END = CW'(STAGGER_CYC - 1);
    // Group enables land one cycle after the index update, so SETTLE absorbs
    // that cycle to keep STAGGER_CYC + ISO_SETTLE_CYC from the last enable.
    localparam logic [CW-1:0] SET_END = CW'(ISO_SETTLE_CYC);
    localparam logic [CW-1:0] TO_END  = CW'(SUPPLY_TO_CYC - 1);
    localparam logic [GW-1:0] G_LAST  = GW'(N_GROUPS - 1);

    logic vddio_ok;
    logic vdd_ok;
    logic sup_ok;

    io_sync2 u_sync_vddio (.clk(clk), .rst_n(rst_n), .d_i(bus.vddio_good_a), .q_o(vddio_ok));
    io_sync2 u_sync_vdd   (.clk(clk), .rst_n(rst_n), .d_i(bus.vdd_good_a),   .q_o(vdd_ok));

    assign sup_ok = vddio_ok & vdd_ok;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [GW-1:0]       g_q, g_d;
    logic [N_GROUPS-1:0] grp_en_q, grp_en_d;
    logic                iso_q, iso_d;
    logic                rdy_q, rdy_d;
    logic                flt_q, flt_d;

    logic [GW-1:0] hi_idx;
    logic          any_en;
    logic          powered;
    logic          can_abort;

    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < N_GROUPS; i++) begin
            if (grp_en_q[i]) hi_idx = GW'(i);
        end
    end

    assign any_en    = |grp_en_q;
    assign powered   = (state_q == ST_RAMP_UP) || (state_q == ST_SETTLE) ||
                       (state_q == ST_ON)      || (state_q == ST_RAMP_DN);
    assign can_abort = (state_q == ST_RAMP_UP) || (state_q == ST_SETTLE) ||
                       (state_q == ST_ON);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            g_q      <= '0;
            grp_en_q <= '0;
            iso_q    <= 1'b1;
            rdy_q    <= 1'b0;
            flt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            g_q      <= g_d;
            grp_en_q <= grp_en_d;
            iso_q    <= iso_d;
            rdy_q    <= rdy_d;
            flt_q    <= flt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        g_d      = g_q;
        grp_en_d = grp_en_q;
        iso_d    = iso_q;
        rdy_d    = rdy_q;
        flt_d    = flt_q;

        unique case (state_q)
            ST_OFF: begin
                grp_en_d = '0;
                iso_d    = 1'b1;
                rdy_d    = 1'b0;
                if (bus.pwr_up_req) begin
                    state_d = ST_WAIT_SUP;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_SUP: begin
                if (sup_ok) begin
                    state_d = ST_RAMP_UP;
                    g_d     = '0;
                    cnt_d   = '0;
                end else if (cnt_q == TO_END) begin
                    state_d = ST_FAULT;
                    flt_d   = 1'b1;
                end else if (!bus.pwr_up_req) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RAMP_UP: begin
                grp_en_d[g_q] = 1'b1;
                if (cnt_q == STG_END) begin
                    cnt_d = '0;
                    if (g_q == G_LAST) state_d = ST_SETTLE;
                    else               g_d     = g_q + GW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SET_END) begin
                    state_d = ST_ON;
                    iso_d   = 1'b0;
                    rdy_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ON: begin
            end
            ST_RAMP_DN: begin
                if (cnt_q == STG_END) begin
                    cnt_d = '0;
                    if (g_q == '0) begin
                        state_d = ST_OFF;
                    end else begin
                        g_d                   = g_q - GW'(1);
                        grp_en_d[g_q - GW'(1)] = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_FAULT: begin
                grp_en_d = '0;
                iso_d    = 1'b1;
                rdy_d    = 1'b0;
                if (bus.fault_clr && !bus.pwr_up_req) begin
                    state_d = ST_OFF;
                    flt_d   = 1'b0;
                end
            end
            default: begin
                state_d  = ST_FAULT;
                grp_en_d = '0;
                iso_d    = 1'b1;
                rdy_d    = 1'b0;
                flt_d    = 1'b1;
            end
        endcase

        // Supply loss outranks a request drop arriving in the same cycle.
        if (powered && !sup_ok) begin
            state_d  = ST_FAULT;
            grp_en_d = '0;
            iso_d    = 1'b1;
            rdy_d    = 1'b0;
            flt_d    = 1'b1;
            cnt_d    = '0;
        end else if (can_abort && !bus.pwr_up_req) begin
            iso_d = 1'b1;
            rdy_d = 1'b0;
            cnt_d = '0;
            if (any_en) begin
                state_d          = ST_RAMP_DN;
                g_d              = hi_idx;
                grp_en_d         = grp_en_q;
                grp_en_d[hi_idx] = 1'b0;
            end else begin
                state_d  = ST_OFF;
                grp_en_d = '0;
            end
        end
    end

    assign bus.grp_en_o     = grp_en_q;
    assign bus.iso_en_o     = iso_q;
    assign bus.ring_ready_o = rdy_q;
    assign bus.fault_o      = flt_q;
    assign bus.state_o      = state_q;

endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// Bench for io_ring_pwr_seq: vector table for the nominal up/down sequence,
// hand-written sequences for timeout, supply loss, abort and reset.
module tb_io_ring_pwr_seq;
    import io_ring_seq_pkg::*;

    localparam int W = 10;

    typedef struct {
        logic       req;
        int         cyc;
        logic [3:0] grp;
        logic       iso;
        logic       rdy;
        logic       flt;
        state_t     st;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    io_ring_pwr_seq_if #(.N_GROUPS(4)) bus ();

    io_ring_pwr_seq #(
        .N_GROUPS(4),
        .STAGGER_CYC(16),
        .ISO_SETTLE_CYC(8),
        .SUPPLY_TO_CYC(1024)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [W-1:0] exp_q[$];
    vec_t       vecs[19];

    function automatic logic [W-1:0] pack(input logic [3:0] g, input logic iso,
                                          input logic rdy, input logic flt, input state_t st);
        return {g, iso, rdy, flt, st};
    endfunction

    function automatic logic [W-1:0] actual();
        return {bus.grp_en_o, bus.iso_en_o, bus.ring_ready_o, bus.fault_o, bus.state_o};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic compare(input string name);
        logic [W-1:0] e;
        logic [W-1:0] a;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: no expected value queued", name);
        end else begin
            e = exp_q.pop_front();
            a = actual();
            if (a !== e) begin
                n_errors++;
                $display("FAIL %s: got grp=%b iso=%b rdy=%b flt=%b st=%0d, expected grp=%b iso=%b rdy=%b flt=%b st=%0d",
                         name, a[9:6], a[5], a[4], a[3], a[2:0], e[9:6], e[5], e[4], e[3], e[2:0]);
            end
        end
    endtask

    task automatic check(input string name, input logic [W-1:0] e);
        exp_q.push_back(e);
        compare(name);
    endtask

    initial begin
        int   cur;
        logic rdy_seen;

        rst_n            = 1'b0;
        bus.pwr_up_req   = 1'b0;
        bus.vddio_good_a = 1'b1;
        bus.vdd_good_a   = 1'b1;
        bus.fault_clr    = 1'b0;

        vecs[0]  = '{1'b1,  1, 4'b0000, 1'b1, 1'b0, 1'b0, ST_WAIT_SUP};
        vecs[1]  = '{1'b1,  2, 4'b0000, 1'b1, 1'b0, 1'b0, ST_RAMP_UP};
        vecs[2]  = '{1'b1,  3, 4'b0001, 1'b1, 1'b0, 1'b0, ST_RAMP_UP};
        vecs[3]  = '{1'b1, 18, 4'b0001, 1'b1, 1'b0, 1'b0, ST_RAMP_UP};
        vecs[4]  = '{1'b1, 19, 4'b0011, 1'b1, 1'b0, 1'b0, ST_RAMP_UP};
        vecs[5]  = '{1'b1, 35, 4'b0111, 1'b1, 1'b0, 1'b0, ST_RAMP_UP};
        vecs[6]  = '{1'b1, 50, 4'b0111, 1'b1, 1'b0, 1'b0, ST_RAMP_UP};
        vecs[7]  = '{1'b1, 51, 4'b1111, 1'b1, 1'b0, 1'b0, ST_RAMP_UP};
        vecs[8]  = '{1'b1, 74, 4'b1111, 1'b1, 1'b0, 1'b0, ST_SETTLE};
        vecs[9]  = '{1'b1, 75, 4'b1111, 1'b0, 1'b1, 1'b0, ST_ON};
        vecs[10] = '{1'b1, 90, 4'b1111, 1'b0, 1'b1, 1'b0, ST_ON};
        vecs[11] = '{1'b0,  1, 4'b0111, 1'b1, 1'b0, 1'b0, ST_RAMP_DN};
        vecs[12] = '{1'b0, 16, 4'b0111, 1'b1, 1'b0, 1'b0, ST_RAMP_DN};
        vecs[13] = '{1'b0, 17, 4'b0011, 1'b1, 1'b0, 1'b0, ST_RAMP_DN};
        vecs[14] = '{1'b0, 33, 4'b0001, 1'b1, 1'b0, 1'b0, ST_RAMP_DN};
        vecs[15] = '{1'b0, 48, 4'b0001, 1'b1, 1'b0, 1'b0, ST_RAMP_DN};
        vecs[16] = '{1'b0, 49, 4'b0000, 1'b1, 1'b0, 1'b0, ST_RAMP_DN};
        vecs[17] = '{1'b0, 64, 4'b0000, 1'b1, 1'b0, 1'b0, ST_RAMP_DN};
        vecs[18] = '{1'b0, 65, 4'b0000, 1'b1, 1'b0, 1'b0, ST_OFF};

        tick(2);
        check("reset", pack(4'b0000, 1'b1, 1'b0, 1'b0, ST_OFF));
        rst_n = 1'b1;
        tick(3);
        check("idle", pack(4'b0000, 1'b1, 1'b0, 1'b0, ST_OFF));

        // Nominal power-up then power-down; cycle count restarts at each req edge.
        cur = 0;
        for (int i = 0; i < 19; i++) begin
            if (vecs[i].req !== bus.pwr_up_req) begin
                bus.pwr_up_req = vecs[i].req;
                cur = 0;
            end
            while (cur < vecs[i].cyc) begin
                tick(1);
                cur++;
            end
            check($sformatf("vec%0d", i),
                  pack(vecs[i].grp, vecs[i].iso, vecs[i].rdy, vecs[i].flt, vecs[i].st));
        end

        // Core supply never good: timeout, then fault_clr gated by the request.
        bus.vdd_good_a = 1'b0;
        tick(3);
        bus.pwr_up_req = 1'b1;
        tick(1024);
        check("to_wait", pack(4'b0000, 1'b1, 1'b0, 1'b0, ST_WAIT_SUP));
        tick(1);
        check("to_fault", pack(4'b0000, 1'b1, 1'b0, 1'b1, ST_FAULT));
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        tick(1);
        check("clr_ignored", pack(4'b0000, 1'b1, 1'b0, 1'b1, ST_FAULT));
        bus.pwr_up_req = 1'b0;
        tick(2);
        check("fault_hold", pack(4'b0000, 1'b1, 1'b0, 1'b1, ST_FAULT));
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        check("clr_off", pack(4'b0000, 1'b1, 1'b0, 1'b0, ST_OFF));
        bus.vdd_good_a = 1'b1;
        tick(3);

        // IO supply lost while ON.
        bus.pwr_up_req = 1'b1;
        tick(75);
        check("on_again", pack(4'b1111, 1'b0, 1'b1, 1'b0, ST_ON));
        bus.vddio_good_a = 1'b0;
        tick(3);
        check("sup_drop", pack(4'b0000, 1'b1, 1'b0, 1'b1, ST_FAULT));
        bus.vddio_good_a = 1'b1;
        bus.pwr_up_req   = 1'b0;
        bus.fault_clr    = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        check("drop_clr", pack(4'b0000, 1'b1, 1'b0, 1'b0, ST_OFF));
        tick(3);

        // Request dropped mid ramp-up with two groups enabled.
        bus.pwr_up_req = 1'b1;
        tick(19);
        check("abort_pre", pack(4'b0011, 1'b1, 1'b0, 1'b0, ST_RAMP_UP));
        bus.pwr_up_req = 1'b0;
        rdy_seen = 1'b0;
        tick(1);
        rdy_seen |= bus.ring_ready_o;
        check("abort_dn1", pack(4'b0001, 1'b1, 1'b0, 1'b0, ST_RAMP_DN));
        for (int c = 21; c <= 52; c++) begin
            tick(1);
            rdy_seen |= bus.ring_ready_o;
            if (c == 35) check("abort_c35", pack(4'b0001, 1'b1, 1'b0, 1'b0, ST_RAMP_DN));
            if (c == 36) check("abort_c36", pack(4'b0000, 1'b1, 1'b0, 1'b0, ST_RAMP_DN));
            if (c == 52) check("abort_off", pack(4'b0000, 1'b1, 1'b0, 1'b0, ST_OFF));
        end
        n_checks++;
        if (rdy_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_rdy: ring_ready_o seen=%b, required 0", rdy_seen);
        end
        tick(2);

        // Asynchronous reset during SETTLE, then a full re-run.
        bus.pwr_up_req = 1'b1;
        tick(70);
        check("settle", pack(4'b1111, 1'b1, 1'b0, 1'b0, ST_SETTLE));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", pack(4'b0000, 1'b1, 1'b0, 1'b0, ST_OFF));
        bus.pwr_up_req = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        bus.pwr_up_req = 1'b1;
        tick(3);
        check("rerun_g0", pack(4'b0001, 1'b1, 1'b0, 1'b0, ST_RAMP_UP));
        tick(72);
        check("rerun_on", pack(4'b1111, 1'b0, 1'b1, 1'b0, ST_ON));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/io_ring_pwr_seq.md
# io_ring_pwr_seq

Power-up/power-down sequencer for the GF22FDX IO pad ring. It waits for the IO and core supplies to report good, then enables pad groups one at a time to limit inrush. Only after every group is on does it release core-side isolation. It sits in the always-on domain next to the IO ring supply cells and drives the ring's group-enable and isolation controls.

## Interface
- N_GROUPS, 4, number of independently enabled pad groups (1..8)
- STAGGER_CYC, 16, cycles between successive group enables/disables (≥1)
- ISO_SETTLE_CYC, 8, cycles from last group enable to isolation release (≥1)
- SUPPLY_TO_CYC, 1024, supply-good timeout in WAIT_SUP (≥1)

- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pwr_up_req  in  1  level request: 1 = ring powered, 0 = ring off
- vddio_good_a  in  1  async IO-supply-good flag, synchronized internally
- vdd_good_a  in  1  async core-supply-good flag, synchronized internally
- fault_clr  in  1  single-cycle pulse, clears FAULT
- grp_en_o  out  N_GROUPS  per-group pad enable
- iso_en_o  out  1  1 = core-side pad signals isolated/clamped
- ring_ready_o  out  1  ring fully up, isolation released
- fault_o  out  1  supply timeout or supply loss latched
- state_o  out  3  current FSM state encoding, for debug

## Operation
- Reset values: grp_en_o=0, iso_en_o=1, ring_ready_o=0, fault_o=0, state OFF. All outputs are registered.
- Supply flags pass through 2-flop synchronizers. sup_ok = both synchronized flags high.
- OFF: all enables 0, iso 1. pwr_up_req=1 → WAIT_SUP with the timeout counter cleared.
- WAIT_SUP:
  - sup_ok → RAMP_UP, group index g=0.
  - Counter reaches SUPPLY_TO_CYC-1 without sup_ok → FAULT.
  - pwr_up_req=0 → OFF.
  - If sup_ok and the timeout occur in the same cycle, sup_ok wins.
- RAMP_UP: set grp_en[g] on entry, then count STAGGER_CYC cycles. Then g++ and set the next group. After the last group's interval → SETTLE.
- SETTLE: count ISO_SETTLE_CYC cycles, then → ON. iso_en_o=0 and ring_ready_o=1 in the same registered update.
- ON: hold. pwr_up_req=0 → RAMP_DN. iso_en_o=1 and ring_ready_o=0 on the first RAMP_DN cycle.
- RAMP_DN: clear the highest set group, wait STAGGER_CYC, clear the next lower group, down to group 0. After the final interval → OFF.
- pwr_up_req=0 during RAMP_UP or SETTLE → RAMP_DN, starting from the highest currently enabled group.
- pwr_up_req=1 during RAMP_DN is ignored until OFF is reached, then re-ramps normally.
- sup_ok=0 in RAMP_UP, SETTLE, ON or RAMP_DN → FAULT. On the next edge: grp_en_o=0 (all at once, no stagger), iso_en_o=1, ring_ready_o=0, fault_o=1.
- FAULT: outputs held safe.
  - fault_clr with pwr_up_req=0 → OFF, fault_o cleared.
  - fault_clr with pwr_up_req=1 is ignored.
- Supply loss takes priority over a request change in the same cycle.
- rst_n assertion mid-sequence forces reset values immediately. No staggered shutdown.
- Counter width: $clog2 of the largest cycle parameter, plus 1. No wrap is reachable.

## Timing
- Supplies already good: grp_en_o[0] rises 3 cycles after pwr_up_req is first sampled high (1 cycle to enter WAIT_SUP, 1 cycle sync pipeline already settled, 1 cycle entering RAMP_UP).
- grp_en_o[k] rises exactly STAGGER_CYC cycles after grp_en_o[k-1].
- ring_ready_o rises STAGGER_CYC + ISO_SETTLE_CYC cycles after the last group enable.
- Async supply drop reaches the outputs in at most 3 cycles: 2 sync + 1 registered.
- Power-down: grp_en_o[N-1] falls with iso_en_o rising. Each lower group follows STAGGER_CYC later.

## Structure
- Package io_ring_seq_pkg holds:
  - state enum: OFF, WAIT_SUP, RAMP_UP, SETTLE, ON, RAMP_DN, FAULT (3-bit)
  - default cycle constants
  - the counter-width function
- Sub-module io_sync2: parameterless 2-flop synchronizer with async active-low reset to 0, instanced once per supply flag.

## Test plan
- Supplies high, pwr_up_req 0→1 (defaults) → grp_en_o steps 0001, 0011, 0111, 1111 at cycles 3, 19, 35, 51; iso_en_o=0 and ring_ready_o=1 at cycle 75.
- ON, then pwr_up_req 1→0 → iso_en_o=1 next cycle; groups clear 1000 first, then every 16 cycles; OFF after 64 cycles.
- vdd_good_a held low, pwr_up_req=1 → fault_o=1 after 1024 cycles; fault_clr ignored until pwr_up_req=0, then state OFF.
- ON, vddio_good_a drops → within 3 cycles grp_en_o=0000, iso_en_o=1, fault_o=1, ring_ready_o=0.
- pwr_up_req drops while grp_en_o=0011 → RAMP_DN clears bit 1 immediately, bit 0 16 cycles later; ring_ready_o never rises.
- rst_n pulsed low during SETTLE → outputs return to reset values asynchronously; a request afterwards runs the full sequence again.
